// File: rtl/axi_wr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_wr_arb_pkg
// Description : Shared types, constants and helpers for the AXI write-port
//               arbiter and its grant-ordering FIFO.
//               - PSEL       : port-select width for the default 2-port build
//               - aw_state_t : AW arbitration FSM states
//               - aw_req_t   : AW request fields at the default widths
//               - clog2      : ceiling log2 for parameter arithmetic
// Revision    : 1.0 - initial release
// ============================================================================
package axi_wr_arb_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   localparam int DEF_NUM_PORTS = 2;
   localparam int PSEL          = clog2(DEF_NUM_PORTS);

   typedef enum logic [0:0] {
      AW_IDLE  = 1'b0,
      AW_ISSUE = 1'b1
   } aw_state_t;

   // Field layout of one AW request at the default widths
   // (ID 4, address 29, length 9, QoS 4).
   typedef struct packed {
      logic [3:0]  id;
      logic [28:0] addr;
      logic [8:0]  len;
      logic [3:0]  qos;
   } aw_req_t;

endpackage : axi_wr_arb_pkg
`default_nettype wire

// File: rtl/arb_grant_fifo.sv
`default_nettype none
// ============================================================================
// Module      : arb_grant_fifo
// Description : Synchronous FIFO of port indices that records the order in
//               which AW grants were issued, so write data (or read data) can
//               be steered in the same order.
// Ports       : clk    - clock
//               rst_n  - asynchronous active-low reset (FIFO becomes empty)
//               push   - write din (accepted when not full, or when full and
//                        popping in the same cycle)
//               din    - entry to write
//               pop    - discard head entry (ignored when empty)
//               head   - oldest entry
//               full   - DEPTH entries held
//               empty  - no entries held
//               level  - current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module arb_grant_fifo
   import axi_wr_arb_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic [WIDTH-1:0]        din,
   input  logic                    pop,
   output logic [WIDTH-1:0]        head,
   output logic                    full,
   output logic                    empty,
   output logic [clog2(DEPTH):0]   level
);

   localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != '0);
   // A pop in the same cycle frees the slot, so push is legal even when full.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only observed through valid pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign level = count;

endmodule : arb_grant_fifo
`default_nettype wire

// File: rtl/axi_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_wr_arbiter
// Description : Shares one AXI4 write port (AW/W/B) among NUM_PORTS upstream
//               write engines. AW is arbitrated round-robin (or QoS-first with
//               round-robin tie-break when AXI_WR_ARB_QOS_EN is defined), W
//               beats follow AW grant order via a grant FIFO, and B responses
//               are routed back by the low ID bits.
// Macro       : AXI_WR_ARB_QOS_EN - highest s_awqos wins among valid ports.
// Ports       : axi_aclk / axi_resetn - clock, async active-low reset
//               s_aw*  - per-port AW channel, packed with port 0 at LSB
//               s_w*   - per-port W channel, packed with port 0 at LSB
//               s_b*   - per-port B valid/ready, broadcast bresp
//               m_aw*, m_w*, m_b* - single downstream AXI write port
//               gfifo_level - grant FIFO occupancy (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module axi_wr_arbiter
   import axi_wr_arb_pkg::*;
#(
   parameter int NUM_PORTS   = 2,
   parameter int ASIZE       = 29,
   parameter int LSIZE       = 9,
   parameter int AXI_DSIZE   = 256,
   parameter int IDSIZE      = 4,
   parameter int GFIFO_DEPTH = 4
)(
   input  logic                            axi_aclk,
   input  logic                            axi_resetn,
   input  logic [NUM_PORTS*IDSIZE-1:0]     s_awid,
   input  logic [NUM_PORTS*ASIZE-1:0]      s_awaddr,
   input  logic [NUM_PORTS*LSIZE-1:0]      s_awlen,
   input  logic [NUM_PORTS*4-1:0]          s_awqos,
   input  logic [NUM_PORTS-1:0]            s_awvalid,
   output logic [NUM_PORTS-1:0]            s_awready,
   input  logic [NUM_PORTS*AXI_DSIZE-1:0]  s_wdata,
   input  logic [NUM_PORTS-1:0]            s_wlast,
   input  logic [NUM_PORTS-1:0]            s_wvalid,
   output logic [NUM_PORTS-1:0]            s_wready,
   output logic [1:0]                      s_bresp,
   output logic [NUM_PORTS-1:0]            s_bvalid,
   input  logic [NUM_PORTS-1:0]            s_bready,
   output logic [IDSIZE-1:0]               m_awid,
   output logic [ASIZE-1:0]                m_awaddr,
   output logic [LSIZE-1:0]                m_awlen,
   output logic [3:0]                      m_awqos,
   output logic                            m_awvalid,
   input  logic                            m_awready,
   output logic [AXI_DSIZE-1:0]            m_wdata,
   output logic                            m_wlast,
   output logic                            m_wvalid,
   input  logic                            m_wready,
   input  logic [IDSIZE-1:0]               m_bid,
   input  logic [1:0]                      m_bresp,
   input  logic                            m_bvalid,
   output logic                            m_bready,
   output logic [clog2(GFIFO_DEPTH):0]     gfifo_level
);

   localparam int PS = (clog2(NUM_PORTS) < 1) ? 1 : clog2(NUM_PORTS);

   aw_state_t     state_q;
   aw_state_t     state_d;
   logic [PS-1:0] rr_q;
   logic [PS-1:0] winner_q;
   logic [PS-1:0] pick;
   logic [PS:0]   cand;
   logic          found;
   logic          aw_grant;
   logic          aw_push;
   logic [PS-1:0] head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          w_pop;
   logic [PS-1:0] bidx;
   logic          bid_ok;
`ifdef AXI_WR_ARB_QOS_EN
   logic [3:0]    best_qos;
`endif

   // ---------------------------------------------------------------------
   // Winner selection: scan ports starting at rr_q, wrapping at NUM_PORTS.
   // With QoS enabled only ports at the highest valid QoS are eligible.
   // ---------------------------------------------------------------------
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
`ifdef AXI_WR_ARB_QOS_EN
      best_qos = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (s_awvalid[p] && (s_awqos[p*4 +: 4] > best_qos)) best_qos = s_awqos[p*4 +: 4];
      end
`endif
      for (int k = 0; k < NUM_PORTS; k++) begin
         cand = (PS+1)'(rr_q) + (PS+1)'(k);
         if (cand >= (PS+1)'(NUM_PORTS)) cand = cand - (PS+1)'(NUM_PORTS);
`ifdef AXI_WR_ARB_QOS_EN
         if (!found && s_awvalid[cand[PS-1:0]] && (s_awqos[cand[PS-1:0]*4 +: 4] == best_qos)) begin
`else
         if (!found && s_awvalid[cand[PS-1:0]]) begin
`endif
            found = 1'b1;
            pick  = cand[PS-1:0];
         end
      end
   end

   // ---------------------------------------------------------------------
   // AW FSM
   // ---------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      aw_grant = 1'b0;
      aw_push  = 1'b0;
      case (state_q)
         AW_IDLE: begin
            // Only one grant can be in flight, so space seen here is still
            // available when the push happens in ISSUE.
            if (found && !fifo_full) begin
               aw_grant = 1'b1;
               state_d  = AW_ISSUE;
            end
         end
         AW_ISSUE: begin
            if (m_awready) begin
               aw_push = 1'b1;
               state_d = AW_IDLE;
            end
         end
         default: state_d = AW_IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_q  <= AW_IDLE;
         rr_q     <= '0;
         winner_q <= '0;
         m_awid   <= '0;
         m_awaddr <= '0;
         m_awlen  <= '0;
         m_awqos  <= '0;
      end else begin
         state_q <= state_d;
         if (aw_grant) begin
            winner_q <= pick;
            m_awid   <= s_awid[pick*IDSIZE +: IDSIZE];
            m_awaddr <= s_awaddr[pick*ASIZE +: ASIZE];
            m_awlen  <= s_awlen[pick*LSIZE +: LSIZE];
            m_awqos  <= s_awqos[pick*4 +: 4];
         end
         if (aw_push) begin
            rr_q <= (winner_q == PS'(NUM_PORTS-1)) ? '0 : winner_q + 1'b1;
         end
      end
   end

   assign m_awvalid = (state_q == AW_ISSUE);

   // ---------------------------------------------------------------------
   // Grant FIFO: remembers AW order so W beats follow it.
   // ---------------------------------------------------------------------
   arb_grant_fifo #(
      .WIDTH (PS),
      .DEPTH (GFIFO_DEPTH)
   ) u_gfifo (
      .clk   (axi_aclk),
      .rst_n (axi_resetn),
      .push  (aw_push),
      .din   (winner_q),
      .pop   (w_pop),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (gfifo_level)
   );

   // ---------------------------------------------------------------------
   // W mux: only the port at the FIFO head is forwarded.
   // ---------------------------------------------------------------------
   assign m_wvalid = !fifo_empty && s_wvalid[head];
   assign m_wlast  = !fifo_empty && s_wlast[head];
   assign m_wdata  = fifo_empty ? '0 : s_wdata[head*AXI_DSIZE +: AXI_DSIZE];
   assign w_pop    = m_wvalid && m_wready && m_wlast;

   // ---------------------------------------------------------------------
   // B routing: full ID must name an existing port, otherwise the
   // response is acknowledged here and dropped.
   // ---------------------------------------------------------------------
   assign bidx     = m_bid[PS-1:0];
   assign bid_ok   = ({1'b0, m_bid} < (IDSIZE+1)'(NUM_PORTS));
   assign m_bready = bid_ok ? s_bready[bidx] : 1'b1;
   assign s_bresp  = m_bresp;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      assign s_awready[i] = aw_grant && (pick == PS'(i));
      assign s_wready[i]  = !fifo_empty && (head == PS'(i)) && m_wready;
      assign s_bvalid[i]  = m_bvalid && bid_ok && (bidx == PS'(i));
   end

endmodule : axi_wr_arbiter
`default_nettype wire
